fifo_read_drain: RTL and testbench

Read-domain controller for the asynchronous FIFO. It synchronizes the write pointer into `r_clk` and owns the read pointer and the empty flag. It drives the memory read enable and re-presents the memory's registered read data as a valid/ready stream with full throughput under backpressure. It sits between the FIFO memory read port and the downstream consumer. It is the counterpart of the write-side pointer/full logic.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/fifo_read_drain.sv | 120 ++++++++++++
 tb/tb_fifo_read_drain.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default sizes, pointer type
// and the Gray/binary conversions used by both pointer domains.
package fifo_pkg;

  localparam int unsigned DEF_DATA_SIZE = 8;
  localparam int unsigned DEF_PTR_SIZE  = 8;
  localparam int unsigned CONV_W        = 32;

  typedef logic [DEF_PTR_SIZE:0] ptr_t;

  // Binary to reflected Gray; callers zero-extend narrower pointers
  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray to binary by prefix XOR from the MSB down
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b[CONV_W-1] = g[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Capture the asynchronous input then re-register it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_read_drain.sv
// Read-domain controller of the async FIFO: write-pointer sync, read pointer,
// empty flag and a 2-entry skid buffer presenting memory data as valid/ready.
// Optional feature macro: FIFO_RD_OCC_EN (registered occupancy on rd_count).
module fifo_read_drain
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned PTR_SIZE  = DEF_PTR_SIZE
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  input  logic [PTR_SIZE:0]    g_wptr,
  input  logic [DATA_SIZE-1:0] data_out,
  output logic                 r_en,
  output logic [PTR_SIZE:0]    b_rptr,
  output logic [PTR_SIZE:0]    g_rptr,
  output logic                 empty,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic [PTR_SIZE:0]    rd_count
);

  localparam int unsigned PW = PTR_SIZE + 1;

  logic [PW-1:0]        g_wptr_s;
  logic [PW-1:0]        b_rptr_nxt;
  logic [PW-1:0]        g_rptr_nxt;
  logic                 empty_nxt;
  logic                 inflight;
  logic                 pop;
  logic [2:0]           occ;
  logic [1:0]           buf_cnt;
  logic [1:0]           buf_cnt_nxt;
  logic [DATA_SIZE-1:0] buf1;
  logic [DATA_SIZE-1:0] buf0_nxt;
  logic [DATA_SIZE-1:0] buf1_nxt;

  sync_2ff #(.WIDTH(PW)) u_wptr_sync (
    .clk   (r_clk),
    .rst_n (r_rst_n),
    .d     (g_wptr),
    .q     (g_wptr_s)
  );

  // Issue a read only when the buffer can absorb it after this cycle's pop
  always_comb begin
    pop        = m_valid & m_ready;
    occ        = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
    r_en       = ~empty & (occ <= 3'd1);
    b_rptr_nxt = b_rptr + PW'(r_en);
    g_rptr_nxt = PW'(bin2gray(CONV_W'(b_rptr_nxt)));
    empty_nxt  = (g_rptr_nxt == g_wptr_s);
  end

  // Buffer next state: push the word landing from memory, drop the head on pop
  always_comb begin
    buf0_nxt    = m_data;
    buf1_nxt    = buf1;
    buf_cnt_nxt = buf_cnt;
    case ({inflight, pop})
      2'b10: begin
        if (buf_cnt == 2'd0) buf0_nxt = data_out;
        else                 buf1_nxt = data_out;
        buf_cnt_nxt = buf_cnt + 2'd1;
      end
      2'b01: begin
        buf0_nxt    = buf1;
        buf_cnt_nxt = buf_cnt - 2'd1;
      end
      2'b11: begin
        if (buf_cnt == 2'd1) begin
          buf0_nxt = data_out;
        end else begin
          buf0_nxt = buf1;
          buf1_nxt = data_out;
        end
      end
      default: ;
    endcase
  end

  // Pointer, flag and buffer registers
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      b_rptr   <= '0;
      g_rptr   <= '0;
      empty    <= 1'b1;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      buf1     <= '0;
    end else begin
      b_rptr   <= b_rptr_nxt;
      g_rptr   <= g_rptr_nxt;
      empty    <= empty_nxt;
      inflight <= r_en;
      buf_cnt  <= buf_cnt_nxt;
      m_valid  <= (buf_cnt_nxt != 2'd0);
      m_data   <= buf0_nxt;
      buf1     <= buf1_nxt;
    end
  end

`ifdef FIFO_RD_OCC_EN
  logic [PW-1:0] b_wptr_s;

  assign b_wptr_s = PW'(gray2bin(CONV_W'(g_wptr_s)));

  // Occupancy as seen through the synchronized write pointer
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) rd_count <= '0;
    else          rd_count <= b_wptr_s - b_rptr;
  end
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_read_drain.sv
// Bench for fifo_read_drain: memory model, write-pointer driver and a
// scoreboard queue of words expected at the valid/ready output.
module tb_fifo_read_drain;

  localparam int unsigned DW    = 8;
  localparam int unsigned PS    = 4;
  localparam int unsigned PW    = PS + 1;
  localparam int unsigned DEPTH = 16;

  logic          r_clk = 1'b0;
  logic          r_rst_n;
  logic [PW-1:0] g_wptr;
  logic [DW-1:0] data_out = '0;
  logic          r_en;
  logic [PW-1:0] b_rptr;
  logic [PW-1:0] g_rptr;
  logic          empty;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [PW-1:0] rd_count;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_d;
  logic [DW-1:0] hold;
  logic [PW-1:0] wptr;
  logic [PW-1:0] pop_cnt;
  logic [PW-1:0] prev_rptr;
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int valid_cnt   = 0;
  int issue_cnt   = 0;
  int first_v     = -1;
  int last_v      = -1;
  bit wrap_seen   = 1'b0;
  bit addr_wrap   = 1'b0;

  always #5 r_clk = ~r_clk;

  fifo_read_drain #(.DATA_SIZE(DW), .PTR_SIZE(PS)) dut (
    .r_clk    (r_clk),
    .r_rst_n  (r_rst_n),
    .g_wptr   (g_wptr),
    .data_out (data_out),
    .r_en     (r_en),
    .b_rptr   (b_rptr),
    .g_rptr   (g_rptr),
    .empty    (empty),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .rd_count (rd_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic write_words(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wptr[PS-1:0]] = DW'($urandom);
      exp_q.push_back(mem[wptr[PS-1:0]]);
      wptr = wptr + 1'b1;
    end
    g_wptr = gray(wptr);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (!(exp_q.size() == 0 && empty && !m_valid && !r_en) && n < bound) begin
      tick();
      n++;
    end
    check("drain_in_time", 32'(n < bound), 32'd1);
  endtask

  // Synchronous memory read port: data one clock after r_en
  always @(posedge r_clk) begin
    cyc++;
    if (r_en) data_out <= mem[b_rptr[PS-1:0]];
  end

  // Output monitor: scoreboard pop on every accepted word
  always @(negedge r_clk) begin
    if (r_rst_n) begin
      if (r_en) issue_cnt++;
      if (m_valid) begin
        valid_cnt++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (prev_rptr == 5'd31 && b_rptr == 5'd0) wrap_seen = 1'b1;
      if (prev_rptr == 5'd15 && b_rptr == 5'd16) addr_wrap = 1'b1;
      prev_rptr = b_rptr;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("overread", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          exp_d = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(exp_d));
          pop_cnt = pop_cnt + 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int written;
    int guard;
    r_rst_n   = 1'b0;
    g_wptr    = '0;
    m_ready   = 1'b0;
    wptr      = '0;
    pop_cnt   = '0;
    prev_rptr = '0;

    // Reset state
    repeat (3) tick();
    check("rst_r_en",     32'(r_en),     32'd0);
    check("rst_b_rptr",   32'(b_rptr),   32'd0);
    check("rst_g_rptr",   32'(g_rptr),   32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_m_valid",  32'(m_valid),  32'd0);
    check("rst_m_data",   32'(m_data),   32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    r_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_empty",   32'(empty),   32'd1);
      check("idle_r_en",    32'(r_en),    32'd0);
      check("idle_m_valid", 32'(m_valid), 32'd0);
    end

    // Single word: 3-edge empty latency, one read, one output beat
    m_ready = 1'b1;
    write_words(1);
    tick(); check("one_empty_e1", 32'(empty), 32'd1);
    tick(); check("one_empty_e2", 32'(empty), 32'd1);
    tick(); check("one_empty_e3", 32'(empty), 32'd0);
            check("one_r_en_e3",  32'(r_en),  32'd1);
    tick(); check("one_empty_e4", 32'(empty), 32'd1);
            check("one_r_en_e4",  32'(r_en),  32'd0);
            check("one_b_rptr",   32'(b_rptr), 32'd1);
            check("one_g_rptr",   32'(g_rptr), 32'(gray(5'd1)));
    tick(); check("one_valid_e5", 32'(m_valid), 32'd1);
    tick(); check("one_valid_e6", 32'(m_valid), 32'd0);
    check("one_q_empty", 32'(exp_q.size()), 32'd0);
    check("one_rd_count", 32'(rd_count), 32'd0);

    // 16 words at full throughput
    valid_cnt = 0; issue_cnt = 0; first_v = -1; last_v = -1;
    write_words(16);
    wait_drain(80);
    check("burst_valid_cnt", 32'(valid_cnt), 32'd16);
    check("burst_span",      32'(last_v - first_v + 1), 32'd16);
    check("burst_issues",    32'(issue_cnt), 32'd16);
    check("burst_b_rptr",    32'(b_rptr), 32'(wptr));
    check("burst_addr_wrap", 32'(addr_wrap), 32'd1);

    // Backpressure: only two reads outstanding, output held
    m_ready = 1'b0;
    issue_cnt = 0;
    write_words(8);
    repeat (10) tick();
    check("bp_issues",  32'(issue_cnt), 32'd2);
    check("bp_valid",   32'(m_valid),   32'd1);
    check("bp_head",    32'(m_data),    32'(exp_q[0]));
    check("bp_b_rptr",  32'(b_rptr),    32'(PW'(wptr - 5'd6)));
`ifdef FIFO_RD_OCC_EN
    check("bp_rd_count", 32'(rd_count), 32'd6);
`endif
    hold = m_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_data",  32'(m_data),  32'(hold));
      check("bp_hold_valid", 32'(m_valid), 32'd1);
    end
    valid_cnt = 0;
    m_ready = 1'b1;
    wait_drain(60);
    check("bp_b_rptr_end", 32'(b_rptr), 32'(wptr));

    // Random backpressure streaming 20 words across the pointer wrap
    written = 0;
    guard   = 0;
    while ((written < 20 || exp_q.size() != 0) && guard < 600) begin
      m_ready = 1'($urandom_range(0, 1));
      if (written < 20 && PW'(wptr - pop_cnt) < 5'd14) begin
        write_words(1);
        written++;
      end
      tick();
      guard++;
    end
    m_ready = 1'b1;
    wait_drain(60);
    check("wrap_b_rptr", 32'(b_rptr), 32'(wptr));
    check("wrap_g_rptr", 32'(g_rptr), 32'(gray(wptr)));
    check("wrap_empty",  32'(empty),  32'd1);
    check("wrap_seen",   32'(wrap_seen), 32'd1);

    // Asynchronous reset with words buffered and in flight
    m_ready = 1'b0;
    write_words(8);
    repeat (6) tick();
    check("mid_valid_pre", 32'(m_valid), 32'd1);
    #2;
    r_rst_n = 1'b0;
    #1;
    check("mid_r_en",     32'(r_en),     32'd0);
    check("mid_b_rptr",   32'(b_rptr),   32'd0);
    check("mid_g_rptr",   32'(g_rptr),   32'd0);
    check("mid_empty",    32'(empty),    32'd1);
    check("mid_m_valid",  32'(m_valid),  32'd0);
    check("mid_m_data",   32'(m_data),   32'd0);
    check("mid_rd_count", 32'(rd_count), 32'd0);
    g_wptr  = '0;
    wptr    = '0;
    pop_cnt = '0;
    exp_q.delete();
    repeat (2) tick();
    r_rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_valid", 32'(m_valid), 32'd0);
      check("post_rst_empty", 32'(empty),   32'd1);
    end
    write_words(1);
    wait_drain(30);
    check("post_rst_b_rptr", 32'(b_rptr),  32'd1);
    check("post_rst_pops",   32'(pop_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
